// File: rtl/sa_min_tracker.sv
// Collects groups of N absolute-difference samples and presents sum, minimum and
// first-minimum index via valid/ready. Define SA_MAX_TRACK_EN to also track the maximum.
module sa_min_tracker #(
  parameter int W     = 10,
  parameter int N     = 16,
  parameter int IDX_W = 4,
  parameter int SUM_W = 14
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             in_do,
  input  logic [W-1:0]     sa,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] sum_out,
  output logic [W-1:0]     min_out,
  output logic [IDX_W-1:0] min_idx,
  output logic             busy,
  output logic             ovf
`ifdef SA_MAX_TRACK_EN
  ,
  output logic [W-1:0]     max_out,
  output logic [IDX_W-1:0] max_idx
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] count, run_min_idx, min_idx_nx;
  logic [SUM_W-1:0] sum, sum_nx;
  logic [W-1:0]     run_min, min_nx;
  logic             take, accept, drop, first, last;
`ifdef SA_MAX_TRACK_EN
  logic [W-1:0]     run_max, max_nx;
  logic [IDX_W-1:0] run_max_idx, max_idx_nx;
`endif

  // Accumulators are cleared on entering HOLD, so a sample taken on the accept edge
  // naturally becomes index 0 of the next group.
  always_comb begin
    first      = (count == '0);
    last       = (count == IDX_W'(N - 1));
    sum_nx     = sum + SUM_W'(sa);
    min_nx     = run_min;
    min_idx_nx = run_min_idx;
    if (first || (sa < run_min)) begin
      min_nx     = sa;
      min_idx_nx = count;
    end
`ifdef SA_MAX_TRACK_EN
    max_nx     = run_max;
    max_idx_nx = run_max_idx;
    if (first || (sa > run_max)) begin
      max_nx     = sa;
      max_idx_nx = count;
    end
`endif
    take     = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_do) begin
            take     = 1'b1;
            state_nx = last ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (out_ready) begin
            accept   = 1'b1;
            take     = in_do;
            state_nx = in_do ? ACC : IDLE;
          end else if (in_do) begin
            drop = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state       <= IDLE;
      count       <= '0;
      sum         <= '0;
      run_min     <= '1;
      run_min_idx <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
      sum_out     <= '0;
      min_out     <= '0;
      min_idx     <= '0;
`ifdef SA_MAX_TRACK_EN
      run_max     <= '0;
      run_max_idx <= '0;
      max_out     <= '0;
      max_idx     <= '0;
`endif
    end else begin
      state     <= state_nx;
      busy      <= (state_nx == ACC);
      out_valid <= (state_nx == HOLD);
      if (clr || accept) begin
        ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
      if (clr || (take && last)) begin
        count       <= '0;
        sum         <= '0;
        run_min     <= '1;
        run_min_idx <= '0;
`ifdef SA_MAX_TRACK_EN
        run_max     <= '0;
        run_max_idx <= '0;
`endif
      end else if (take) begin
        count       <= count + 1'b1;
        sum         <= sum_nx;
        run_min     <= min_nx;
        run_min_idx <= min_idx_nx;
`ifdef SA_MAX_TRACK_EN
        run_max     <= max_nx;
        run_max_idx <= max_idx_nx;
`endif
      end
      if (!clr && take && last) begin
        sum_out <= sum_nx;
        min_out <= min_nx;
        min_idx <= min_idx_nx;
`ifdef SA_MAX_TRACK_EN
        max_out <= max_nx;
        max_idx <= max_idx_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sa_min_tracker.sv
// Directed bench for sa_min_tracker: an N=4 instance driven from a vector table and
// a default N=16 instance driven by hand-written sequences (max checked under SA_MAX_TRACK_EN).
module tb_sa_min_tracker;

  logic m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  // N=4 instance
  logic        rst4, do4, clr4, rdy4;
  logic [9:0]  sa4;
  logic        v4, busy4, ovf4;
  logic [11:0] sum4;
  logic [9:0]  min4;
  logic [1:0]  idx4;
`ifdef SA_MAX_TRACK_EN
  logic [9:0]  max4;
  logic [1:0]  maxi4;
`endif

  sa_min_tracker #(.W(10), .N(4), .IDX_W(2), .SUM_W(12)) dut4 (
    .m_clock(m_clock), .p_reset(rst4), .in_do(do4), .sa(sa4), .clr(clr4),
    .out_ready(rdy4), .out_valid(v4), .sum_out(sum4), .min_out(min4),
    .min_idx(idx4), .busy(busy4), .ovf(ovf4)
`ifdef SA_MAX_TRACK_EN
    , .max_out(max4), .max_idx(maxi4)
`endif
  );

  // Default N=16 instance
  logic        rst16, do16, clr16, rdy16;
  logic [9:0]  sa16;
  logic        v16, busy16, ovf16;
  logic [13:0] sum16;
  logic [9:0]  min16;
  logic [3:0]  idx16;
`ifdef SA_MAX_TRACK_EN
  logic [9:0]  max16;
  logic [3:0]  maxi16;
`endif

  sa_min_tracker dut16 (
    .m_clock(m_clock), .p_reset(rst16), .in_do(do16), .sa(sa16), .clr(clr16),
    .out_ready(rdy16), .out_valid(v16), .sum_out(sum16), .min_out(min16),
    .min_idx(idx16), .busy(busy16), .ovf(ovf16)
`ifdef SA_MAX_TRACK_EN
    , .max_out(max16), .max_idx(maxi16)
`endif
  );

  typedef struct {
    logic        rst, dov, clr, rdy;
    logic [9:0]  sa;
    logic        ev;
    logic [11:0] esum;
    logic [9:0]  emin;
    logic [1:0]  eidx;
    logic        ebusy, eovf;
  } vec_t;

  vec_t tbl[42];
  int   n_vectors = 0;
  int   n_checks  = 0;
  int   n_miscompares = 0;

  function automatic vec_t mk(logic r, logic d, int s, logic c, logic y,
                              logic v, int es, int em, int ei, logic b, logic o);
    vec_t t;
    t.rst = r; t.dov = d; t.sa = 10'(s); t.clr = c; t.rdy = y;
    t.ev = v; t.esum = 12'(es); t.emin = 10'(em); t.eidx = 2'(ei);
    t.ebusy = b; t.eovf = o;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    rst4 = t.rst; do4 = t.dov; sa4 = t.sa; clr4 = t.clr; rdy4 = t.rdy;
    @(posedge m_clock);
    #1;
    n_vectors++;
  endtask

  task automatic step16(input logic r, input logic d, input int s, input logic y);
    rst16 = r; do16 = d; sa16 = 10'(s); clr16 = 1'b0; rdy16 = y;
    @(posedge m_clock);
    #1;
    n_vectors++;
  endtask

  int vals[16] = '{500, 20, 900, 20, 1000, 7, 1000, 300, 7, 999, 64, 128, 7, 1000, 250, 33};
  int m_sum, m_min, m_idx, m_max, m_midx;

  initial begin
    rst4 = 1'b1; do4 = 1'b0; sa4 = '0; clr4 = 1'b0; rdy4 = 1'b0;
    rst16 = 1'b1; do16 = 1'b0; sa16 = '0; clr16 = 1'b0; rdy16 = 1'b0;

    //              r  d  sa c  y   v  sum min idx busy ovf
    tbl[0]  = mk(1, 0, 0, 0, 0,   0, 0,  0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[2]  = mk(0, 1, 3, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[3]  = mk(0, 1, 7, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[4]  = mk(0, 1, 3, 0, 1,   1, 18, 3,  1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1,   0, 18, 3,  1, 0, 0);
    tbl[6]  = mk(0, 1, 9, 0, 0,   0, 18, 3,  1, 1, 0);
    tbl[7]  = mk(0, 1, 9, 0, 0,   0, 18, 3,  1, 1, 0);
    tbl[8]  = mk(0, 1, 9, 0, 0,   0, 18, 3,  1, 1, 0);
    tbl[9]  = mk(0, 1, 9, 0, 0,   1, 36, 9,  0, 0, 0);
    tbl[10] = mk(0, 1, 2, 0, 0,   1, 36, 9,  0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0,   1, 36, 9,  0, 0, 1);
    tbl[12] = mk(0, 1, 1, 0, 0,   1, 36, 9,  0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1,   0, 36, 9,  0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0,   0, 36, 9,  0, 1, 0);
    tbl[15] = mk(0, 1, 5, 0, 0,   0, 36, 9,  0, 1, 0);
    tbl[16] = mk(0, 1, 5, 0, 0,   0, 36, 9,  0, 1, 0);
    tbl[17] = mk(0, 1, 0, 0, 0,   1, 10, 0,  0, 0, 0);
    tbl[18] = mk(0, 1, 2, 0, 1,   0, 10, 0,  0, 1, 0);
    tbl[19] = mk(0, 1, 6, 0, 1,   0, 10, 0,  0, 1, 0);
    tbl[20] = mk(0, 1, 1, 0, 1,   0, 10, 0,  0, 1, 0);
    tbl[21] = mk(0, 1, 4, 0, 1,   1, 13, 1,  2, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 1,   0, 13, 1,  2, 0, 0);
    tbl[23] = mk(0, 1, 8, 0, 1,   0, 13, 1,  2, 1, 0);
    tbl[24] = mk(0, 1, 8, 0, 1,   0, 13, 1,  2, 1, 0);
    tbl[25] = mk(0, 1, 8, 1, 1,   0, 13, 1,  2, 0, 0);
    tbl[26] = mk(0, 1, 1, 0, 1,   0, 13, 1,  2, 1, 0);
    tbl[27] = mk(0, 1, 1, 0, 1,   0, 13, 1,  2, 1, 0);
    tbl[28] = mk(0, 1, 1, 0, 1,   0, 13, 1,  2, 1, 0);
    tbl[29] = mk(0, 1, 1, 0, 0,   1, 4,  1,  0, 0, 0);
    tbl[30] = mk(0, 1, 7, 0, 0,   1, 4,  1,  0, 0, 1);
    tbl[31] = mk(0, 0, 0, 1, 0,   0, 4,  1,  0, 0, 0);
    tbl[32] = mk(0, 1, 2, 0, 0,   0, 4,  1,  0, 1, 0);
    tbl[33] = mk(0, 1, 2, 0, 0,   0, 4,  1,  0, 1, 0);
    tbl[34] = mk(0, 1, 2, 0, 0,   0, 4,  1,  0, 1, 0);
    tbl[35] = mk(0, 1, 2, 0, 0,   1, 8,  2,  0, 0, 0);
    tbl[36] = mk(1, 1, 3, 0, 0,   0, 0,  0,  0, 0, 0);
    tbl[37] = mk(0, 1, 6, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[38] = mk(0, 1, 5, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[39] = mk(0, 1, 9, 0, 1,   0, 0,  0,  0, 1, 0);
    tbl[40] = mk(0, 1, 5, 0, 1,   1, 25, 5,  1, 0, 0);
    tbl[41] = mk(0, 0, 0, 0, 1,   0, 25, 5,  1, 0, 0);

    for (int i = 0; i < 42; i++) begin
      applyStimulus(tbl[i]);
      checkOutput("out_valid", i, 32'(v4),    32'(tbl[i].ev));
      checkOutput("sum_out",   i, 32'(sum4),  32'(tbl[i].esum));
      checkOutput("min_out",   i, 32'(min4),  32'(tbl[i].emin));
      checkOutput("min_idx",   i, 32'(idx4),  32'(tbl[i].eidx));
      checkOutput("busy",      i, 32'(busy4), 32'(tbl[i].ebusy));
      checkOutput("ovf",       i, 32'(ovf4),  32'(tbl[i].eovf));
    end

    // N=16: reset state, then a full group of 1023s
    step16(1, 0, 0, 0);
    checkOutput("n16_rst_valid", 0, 32'(v16),   0);
    checkOutput("n16_rst_sum",   0, 32'(sum16), 0);
    checkOutput("n16_rst_min",   0, 32'(min16), 0);
    for (int k = 0; k < 16; k++) begin
      step16(0, 1, 1023, 0);
      checkOutput("n16_valid", k, 32'(v16),    (k == 15) ? 1 : 0);
      checkOutput("n16_busy",  k, 32'(busy16), (k == 15) ? 0 : 1);
    end
    checkOutput("n16_sum", 16, 32'(sum16), 16368);
    checkOutput("n16_min", 16, 32'(min16), 1023);
    checkOutput("n16_idx", 16, 32'(idx16), 0);
`ifdef SA_MAX_TRACK_EN
    checkOutput("n16_max",  16, 32'(max16),  1023);
    checkOutput("n16_maxi", 16, 32'(maxi16), 0);
`endif
    step16(0, 0, 0, 1);
    checkOutput("n16_accept_valid", 17, 32'(v16),    0);
    checkOutput("n16_accept_busy",  17, 32'(busy16), 0);

    // N=16: mixed values with ties on both min and max
    m_sum = 0; m_min = 1024; m_idx = 0; m_max = -1; m_midx = 0;
    for (int k = 0; k < 16; k++) begin
      m_sum += vals[k];
      if (vals[k] < m_min) begin m_min = vals[k]; m_idx = k; end
      if (vals[k] > m_max) begin m_max = vals[k]; m_midx = k; end
      step16(0, 1, vals[k], 0);
    end
    checkOutput("n16b_valid", 18, 32'(v16),   1);
    checkOutput("n16b_sum",   18, 32'(sum16), 32'(m_sum));
    checkOutput("n16b_min",   18, 32'(min16), 32'(m_min));
    checkOutput("n16b_idx",   18, 32'(idx16), 32'(m_idx));
`ifdef SA_MAX_TRACK_EN
    checkOutput("n16b_max",  18, 32'(max16),  32'(m_max));
    checkOutput("n16b_maxi", 18, 32'(maxi16), 32'(m_midx));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/sa_min_tracker.md
Name: sa_min_tracker

Overview:
- Downstream consumer of the absolute-difference stage (`sa` = |moto − hikareru|, 10 bit, qualified by `in_do`).
- Collects a group of N difference samples and produces three results per group:
  - running sum of differences,
  - minimum difference,
  - index of the first sample that reached the minimum.
- Hands the result to the maze/UART control path through a valid/ready handshake.
- One clock domain. The difference stage is combinational, so `sa` is sampled in the same cycle as `in_do`.

Parameters:
- W, 10, width of `sa` input.
- N, 16, samples per group. Must be ≥2 and a power of two.
- IDX_W, 4, index width, equal to log2(N).
- SUM_W, 14, sum width, equal to W+IDX_W. Never overflows.

Ports:
- m_clock  in  1  clock; all state updates on the rising edge.
- p_reset  in  1  synchronous, active-high reset.
- in_do  in  1  sample strobe. Same signal that drives the difference stage.
- sa  in  W  difference value; valid when `in_do`=1.
- clr  in  1  synchronous abort of the current group.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result available.
- sum_out  out  SUM_W  sum of the N samples.
- min_out  out  W  minimum sample value.
- min_idx  out  IDX_W  index (0..N-1) of the first sample equal to the minimum.
- busy  out  1  a group is partially collected (state ACC).
- ovf  out  1  sticky: a sample arrived while in HOLD and was dropped.

Behaviour:
- Reset (`p_reset`=1 at a clock edge):
  - state → IDLE; count, sum, `min_idx` → 0; min register → all ones.
  - `out_valid`, `busy`, `ovf` → 0; `sum_out`, `min_out` → 0.
  - Reset in any state, including HOLD, discards everything. `out_valid`=0 from the cycle after the reset edge.
- States:
  - IDLE: no samples held.
  - ACC: 1..N-1 samples held.
  - HOLD: result presented.
- Transition priority, highest first: `p_reset`, then `clr`, then handshake/sample.
- IDLE/ACC, on `in_do`=1:
  - sum ← sum + zero-extended `sa`.
  - If `sa` < current min (strict less-than), min ← `sa` and `min_idx` ← count. A tie keeps the earlier index.
  - count ← count+1.
  - The first sample of a group loads min unconditionally; the IDLE min is treated as all ones.
  - IDLE → ACC on the first sample.
  - On the sample where count = N-1, load the final sum/min/idx into the output registers and enter HOLD. `out_valid`=1 on the next cycle, i.e. latency of 1 clock after the N-th strobe.
- IDLE/ACC, `in_do`=0: hold all state.
- HOLD:
  - Outputs stable while `out_valid`=1 and `out_ready`=0.
  - `in_do` with `out_ready`=0: sample dropped, `ovf` ← 1.
  - Handshake completes when `out_valid` & `out_ready` are both 1 at an edge. Then `out_valid` ← 0, count/sum cleared, min ← all ones.
  - Accept with `in_do`=0: → IDLE.
  - Accept with `in_do`=1 in the same cycle: the sample is index 0 of the next group, state → ACC. Not dropped; `ovf` unchanged.
  - `ovf` clears on the accept edge, unless a sample is dropped in that same cycle (impossible given the rule above).
- `clr`=1:
  - In IDLE/ACC: → IDLE, accumulators cleared. A simultaneous `in_do` is discarded.
  - In HOLD: the result is discarded, `out_valid` ← 0, → IDLE, `ovf` ← 0.
- `busy` = (state == ACC). This is a registered decode.
- `sum_out`, `min_out`, `min_idx` change only when entering HOLD, and reset to 0.

Optional Feature:
- Macro: `SA_MAX_TRACK_EN`.
- Defined:
  - Extra outputs `max_out` [W], `max_idx` [IDX_W].
  - Tracks the maximum with strict greater-than; first index wins ties.
  - Max register initialises to 0 on group start and reset.
  - Outputs are latched into HOLD alongside the min, and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- N=4, `sa` = 5,3,7,3 on consecutive `in_do`, `out_ready`=1 → one cycle after the 4th strobe: `out_valid`=1, `sum_out`=18, `min_out`=3, `min_idx`=1. Next cycle `out_valid`=0.
- N=4, group 9,9,9,9 with `out_ready` held 0 for 3 cycles and `in_do` pulsed twice in HOLD → outputs stable (36/9/0), `ovf`=1. After accept: `ovf`=0, state IDLE.
- Accept edge coincides with `in_do`, `sa`=2, followed by 6,1,4 → second result `sum_out`=13, `min_out`=1, `min_idx`=2.
- 2 samples (8,8), then `clr` together with `in_do`, then 1,1,1,1 → `sum_out`=4, `min_out`=1, `min_idx`=0. The clr-cycle sample is not counted.
- Default N=16, all `sa`=1023 → `sum_out`=16368, `min_idx`=0. With `SA_MAX_TRACK_EN`: `max_out`=1023, `max_idx`=0.
- `p_reset` asserted while in HOLD → the cycle after: `out_valid`=0, all outputs 0, `busy`=0. A following group behaves as after power-up.
